// File: rtl/tick_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tick_stopwatch
// Description : BCD mm:ss stopwatch advanced by upstream tick pulses, with
//               run/pause, clear and lap-freeze controls.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_stopwatch #(
    parameter int TICKS_PER_SEC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       wrap,
    output logic       overflow
);

    localparam int                    c_presc_w   = $clog2(TICKS_PER_SEC) + 1;
    localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(TICKS_PER_SEC - 1);
    localparam logic [c_presc_w-1:0]  c_presc_one = c_presc_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_ss_q;
    logic                 r_clr_q;
    logic                 r_lap_q;
    logic [c_presc_w-1:0] r_presc;
    logic [c_presc_w-1:0] w_presc_next;
    logic [3:0]           r_so;
    logic [2:0]           r_st;
    logic [3:0]           r_mo;
    logic [2:0]           r_mt;
    logic [3:0]           w_so;
    logic [2:0]           w_st;
    logic [3:0]           w_mo;
    logic [2:0]           w_mt;
    logic [3:0]           r_disp_so;
    logic [2:0]           r_disp_st;
    logic [3:0]           r_disp_mo;
    logic [2:0]           r_disp_mt;
    logic                 r_lap_active;
    logic                 w_lap_next;
    logic                 r_wrap;
    logic                 r_overflow;
    logic                 w_overflow_next;
    logic                 w_wrap_now;
    logic                 w_ss_edge;
    logic                 w_clr_edge;
    logic                 w_lap_edge;
    logic                 w_do_clear;
    logic                 w_lap_toggle;
    logic                 w_count;
    logic                 w_sec_adv;

    assign w_ss_edge  = start_stop & ~r_ss_q;
    assign w_clr_edge = clear & ~r_clr_q;
    assign w_lap_edge = lap & ~r_lap_q;

    // start_stop has priority, so a coincident clear edge is dropped
    assign w_do_clear   = w_clr_edge & ~w_ss_edge &
                          ((r_state == c_st_idle) | (r_state == c_st_pause));
    assign w_lap_toggle = w_lap_edge & (r_state == c_st_run);
    assign w_count      = tick & (r_state == c_st_run);
    assign w_sec_adv    = w_count & (r_presc == c_presc_max);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_ss_edge) w_state_next = c_st_run;
            c_st_run:   if (w_ss_edge) w_state_next = c_st_pause;
            c_st_pause: begin
                if (w_ss_edge)       w_state_next = c_st_run;
                else if (w_clr_edge) w_state_next = c_st_idle;
            end
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_presc_next = r_presc;
        if (w_do_clear)
            w_presc_next = '0;
        else if (w_count)
            w_presc_next = (r_presc == c_presc_max) ? '0 : r_presc + c_presc_one;
    end

    // Full BCD carry chain resolves within a single cycle
    always_comb begin
        w_so       = r_so;
        w_st       = r_st;
        w_mo       = r_mo;
        w_mt       = r_mt;
        w_wrap_now = 1'b0;
        if (w_do_clear) begin
            w_so = '0;
            w_st = '0;
            w_mo = '0;
            w_mt = '0;
        end else if (w_sec_adv) begin
            if (r_so == 4'd9) begin
                w_so = 4'd0;
                if (r_st == 3'd5) begin
                    w_st = 3'd0;
                    if (r_mo == 4'd9) begin
                        w_mo = 4'd0;
                        if (r_mt == 3'd5) begin
                            w_mt       = 3'd0;
                            w_wrap_now = 1'b1;
                        end else begin
                            w_mt = r_mt + 3'd1;
                        end
                    end else begin
                        w_mo = r_mo + 4'd1;
                    end
                end else begin
                    w_st = r_st + 3'd1;
                end
            end else begin
                w_so = r_so + 4'd1;
            end
        end
    end

    always_comb begin
        w_lap_next      = r_lap_active;
        w_overflow_next = r_overflow;
        if (w_do_clear) begin
            w_lap_next      = 1'b0;
            w_overflow_next = 1'b0;
        end else begin
            if (w_lap_toggle) w_lap_next      = ~r_lap_active;
            if (w_wrap_now)   w_overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_ss_q       <= 1'b0;
            r_clr_q      <= 1'b0;
            r_lap_q      <= 1'b0;
            r_presc      <= '0;
            r_so         <= '0;
            r_st         <= '0;
            r_mo         <= '0;
            r_mt         <= '0;
            r_lap_active <= 1'b0;
            r_wrap       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ss_q       <= start_stop;
            r_clr_q      <= clear;
            r_lap_q      <= lap;
            r_presc      <= w_presc_next;
            r_so         <= w_so;
            r_st         <= w_st;
            r_mo         <= w_mo;
            r_mt         <= w_mt;
            r_lap_active <= w_lap_next;
            r_wrap       <= w_wrap_now;
            r_overflow   <= w_overflow_next;
        end
    end

    // Freeze captures the pre-increment time; unfrozen display follows next time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_so <= '0;
            r_disp_st <= '0;
            r_disp_mo <= '0;
            r_disp_mt <= '0;
        end else if (!w_lap_next) begin
            r_disp_so <= w_so;
            r_disp_st <= w_st;
            r_disp_mo <= w_mo;
            r_disp_mt <= w_mt;
        end else if (!r_lap_active) begin
            r_disp_so <= r_so;
            r_disp_st <= r_st;
            r_disp_mo <= r_mo;
            r_disp_mt <= r_mt;
        end
    end

    assign sec_ones   = r_disp_so;
    assign sec_tens   = r_disp_st;
    assign min_ones   = r_disp_mo;
    assign min_tens   = r_disp_mt;
    assign running    = (r_state == c_st_run);
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tick_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_stopwatch
// Description : Directed scoreboard bench for tick_stopwatch (TICKS_PER_SEC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_stopwatch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       running;
    logic       lap_active;
    logic       wrap;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    tick_stopwatch #(.TICKS_PER_SEC(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {running, lap_active, wrap, overflow, min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [17:0] model(int secs, bit run, bit lapa, bit wr, bit ov);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {run, lapa, wr, ov, 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic expect_out(string tag, int secs, bit run, bit lapa, bit wr, bit ov);
        sb_item_t it;
        it.tag = tag;
        it.exp = model(secs, run, lapa, wr, ov);
        sb.push_back(it);
    endtask

    task automatic check();
        sb_item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            n_checks++;
            assert (obs === it.exp) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n, int gap);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            repeat (gap - 1) cyc();
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        cyc();
        lap = 1'b0;
    endtask

    initial begin
        expect_out("reset_state", 0, 0, 0, 0, 0);
        #3;
        check();
        cyc();
        cyc();
        reset = 1'b0;

        ticks(8, 5);
        expect_out("idle_ticks_ignored", 0, 0, 0, 0, 0);
        check();

        // Tick coincident with the start edge must not count
        start_stop = 1'b1;
        tick       = 1'b1;
        cyc();
        start_stop = 1'b0;
        tick       = 1'b0;
        expect_out("start_running", 0, 1, 0, 0, 0);
        check();
        ticks(3, 5);
        expect_out("start_tick_uncounted", 0, 1, 0, 0, 0);
        check();
        ticks(1, 5);
        expect_out("first_second", 1, 1, 0, 0, 0);
        check();
        ticks(36, 5);
        expect_out("basic_count_10s", 10, 1, 0, 0, 0);
        check();

        pulse_ss();
        expect_out("pause", 10, 0, 0, 0, 0);
        check();
        cyc();
        ticks(20, 5);
        expect_out("pause_hold", 10, 0, 0, 0, 0);
        check();

        start_stop = 1'b1;
        clear      = 1'b1;
        cyc();
        start_stop = 1'b0;
        clear      = 1'b0;
        expect_out("ss_clear_same_cycle", 10, 1, 0, 0, 0);
        check();
        cyc();
        ticks(4, 5);
        expect_out("resume_count", 11, 1, 0, 0, 0);
        check();

        pulse_lap();
        expect_out("lap_freeze", 11, 1, 1, 0, 0);
        check();
        cyc();
        ticks(8, 5);
        expect_out("lap_held", 11, 1, 1, 0, 0);
        check();
        pulse_lap();
        expect_out("lap_release", 13, 1, 0, 0, 0);
        check();
        cyc();

        pulse_clear();
        expect_out("clear_in_run_ignored", 13, 1, 0, 0, 0);
        check();
        cyc();

        start_stop = 1'b1;
        repeat (50) cyc();
        start_stop = 1'b0;
        expect_out("ss_held_single_toggle", 13, 0, 0, 0, 0);
        check();
        cyc();

        pulse_clear();
        expect_out("clear_in_pause", 0, 0, 0, 0, 0);
        check();
        cyc();
        pulse_lap();
        expect_out("lap_in_idle_ignored", 0, 0, 0, 0, 0);
        check();
        cyc();

        pulse_ss();
        cyc();
        ticks(28, 1);
        expect_out("run_to_7s", 7, 1, 0, 0, 0);
        check();
        #1;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 0, 0, 0, 0, 0);
        check();
        cyc();
        cyc();
        reset = 1'b0;
        ticks(8, 5);
        expect_out("post_reset_idle", 0, 0, 0, 0, 0);
        check();

        pulse_ss();
        cyc();
        ticks(3599 * 4, 1);
        expect_out("reach_59_59", 3599, 1, 0, 0, 0);
        check();
        ticks(4, 1);
        expect_out("wrap_pulse", 0, 1, 0, 1, 1);
        check();
        cyc();
        expect_out("wrap_one_cycle", 0, 1, 0, 0, 1);
        check();
        pulse_clear();
        expect_out("clear_run_keeps_ovf", 0, 1, 0, 0, 1);
        check();
        cyc();
        pulse_ss();
        expect_out("pause_keeps_ovf", 0, 0, 0, 0, 1);
        check();
        cyc();
        pulse_clear();
        expect_out("clear_resets_ovf", 0, 0, 0, 0, 0);
        check();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
